// File: rtl/sub_sched.sv
`default_nettype none
// ============================================================================
//  Module      : sub_sched
//  Description : Round-robin scheduler in front of one shared signed
//                subtract/compare datapath. Each of N_REQ requesters offers
//                an operand pair (A, B) over a valid/ready handshake; the
//                winner's pair is latched, A-B and the signed G/E/L flags are
//                computed once, and the result is returned tagged with the
//                requester index over a valid/ready response port.
//
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset
//                req_valid  - [N_REQ]    per-requester request valid
//                req_ready  - [N_REQ]    per-requester grant (one-hot or zero)
//                req_a      - [N_REQ*W]  operand A, requester i at [i*W +: W]
//                req_b      - [N_REQ*W]  operand B, same packing
//                rsp_valid  - result valid
//                rsp_ready  - consumer accepts result
//                rsp_id     - [IDW] requester that owns the result
//                rsp_diff   - [W+1] sign-extended A-B
//                rsp_g/e/l  - A>B / A==B / A<B (signed)
//                busy       - high whenever not IDLE
//
//  Revision    : 1.0 - initial release
// ============================================================================
module sub_sched #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [W:0]           rsp_diff,
    output logic                 rsp_g,
    output logic                 rsp_e,
    output logic                 rsp_l,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [IDW-1:0] c_last_id = IDW'(N_REQ - 1);

    state_t            r_state;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    r_id;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;

    logic              w_found;
    logic [IDW-1:0]    w_win;
    logic [W-1:0]      w_a;
    logic [W-1:0]      w_b;
    logic              w_grant;

    // Round-robin search. Walking the offsets from the far end back towards
    // the pointer lets the candidate closest to r_ptr overwrite the others,
    // so the final value is the first valid requester at or after r_ptr.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            logic [IDW-1:0] cand;
            cand = IDW'((int'(r_ptr) + k) % N_REQ);
            if (req_valid[cand]) begin
                w_found = 1'b1;
                w_win   = cand;
            end
        end
    end

    assign w_a     = req_a[w_win*W +: W];
    assign w_b     = req_b[w_win*W +: W];
    // rst masks the grant so no requester sees an accept that the reset
    // is about to discard.
    assign w_grant = (r_state == S_IDLE) && w_found && !rst;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = w_grant && (w_win == IDW'(gi));
        end
    endgenerate

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_id      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_diff  <= '0;
            rsp_g     <= 1'b0;
            rsp_e     <= 1'b0;
            rsp_l     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_a     <= w_a;
                        r_b     <= w_b;
                        r_id    <= w_win;
                        r_ptr   <= (w_win == c_last_id) ? '0 : w_win + 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    // One extra bit of headroom makes the difference exact.
                    rsp_diff  <= {r_a[W-1], r_a} - {r_b[W-1], r_b};
                    rsp_g     <= ($signed(r_a) >  $signed(r_b));
                    rsp_e     <= (r_a == r_b);
                    rsp_l     <= ($signed(r_a) <  $signed(r_b));
                    rsp_id    <= r_id;
                    rsp_valid <= 1'b1;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/sub_sched.md
# sub_sched

Round-robin scheduler that shares one signed 4-bit subtract/compare datapath among several requesters. It accepts one operand pair per transaction through a valid/ready handshake and computes the overflow-free difference A−B together with greater/equal/less flags. It returns the result, tagged with the requester index, through a valid/ready response port. It sits between the requesting units and the shared arithmetic resource, so the subtractor and comparator exist once.

## Interface
- N_REQ, default 4, number of requesters (2..8)
- W, default 4, operand width, two's complement
- IDW, default 2, requester-ID width, equal to ceil(log2(N_REQ))
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester grant/accept; at most one bit high per cycle
- req_a  in  N_REQ*W  operand A; requester i occupies bits [i*W +: W]
- req_b  in  N_REQ*W  operand B; same packing as req_a
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of the requester that owns the result
- rsp_diff  out  W+1  A−B, two's complement, sign-extended
- rsp_g, rsp_e, rsp_l  out  1 each  A>B, A==B, A<B (signed); exactly one is high while rsp_valid is high
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, CALC, RESP. Reset state is IDLE.
- IDLE:
  - If any req_valid bit is high, assert req_ready combinationally for the round-robin winner only.
  - On that edge, latch the winner's A, B and index, then go to CALC.
  - If no req_valid bit is high, stay in IDLE with req_ready all zero.
- Round-robin selection:
  - Search starts at pointer ptr and proceeds ptr, ptr+1, … modulo N_REQ.
  - The first requester with req_valid high wins.
  - After a grant to index i, ptr becomes (i+1) mod N_REQ.
  - ptr resets to 0.
- CALC:
  - rsp_diff is registered as sext(A) − sext(B) in W+1 bits. This cannot overflow; the range is −15..+15 for W=4.
  - Flags are registered from the signed comparison.
  - The next state is always RESP.
- RESP:
  - rsp_valid is high.
  - rsp_id, rsp_diff and the flags hold stable until rsp_valid and rsp_ready are both high on the same edge; then go to IDLE.
- req_ready is zero in CALC and RESP. Requesters hold their valid and data until granted; a dropped req_valid simply loses arbitration.
- Reset:
  - Outputs reset to: rsp_valid=0, rsp_id=0, rsp_diff=0, rsp_g=rsp_e=rsp_l=0, busy=0, req_ready=0, ptr=0.
  - A reset asserted in CALC or RESP abandons the transaction, and no response is produced.

## Timing
- Grant happens in the same cycle req_valid is seen in IDLE, because req_ready is combinational from req_valid and ptr.
- Accept edge (req_valid & req_ready) to rsp_valid high takes 2 cycles.
- Response accept edge to the next possible grant takes 1 cycle (IDLE).
- Minimum period is 3 cycles per transaction with rsp_ready held high.
- rsp_* outputs are registered; no combinational path runs from rsp_ready to rsp_*.
- The only combinational input-to-output paths are req_valid → req_ready and rst gating.
- Simultaneous requests are resolved purely by ptr. A requester that is held valid is granted within N_REQ transactions.

## Test plan
- Requester 1 sends A=3, B=5 → req_ready[1] pulses for 1 cycle; 2 cycles later rsp_valid=1, rsp_id=1, rsp_diff=5'b11110 (−2), rsp_l=1.
- Extremes:
  - A=−8, B=7 → rsp_diff=5'b10001 (−15), rsp_l=1.
  - A=7, B=−8 → rsp_diff=5'b01111 (+15), rsp_g=1.
  - A=B=−4 → rsp_diff=0, rsp_e=1.
- After reset, requesters 0 and 2 both hold valid → grants in order 0, 2. Then requesters 0, 1, 2 and 3 are all held valid → grant order 3, 0, 1, 2. Each response carries the matching rsp_id.
- rsp_ready is held low for 5 cycles in RESP → rsp_* stay stable, busy=1, and no req_ready is asserted despite pending requests. When rsp_ready rises, the response is accepted and the next grant follows one cycle later.
- rst is asserted for 1 cycle while in CALC → the next cycle shows IDLE, all outputs at reset values, ptr=0, and no response for the abandoned request.
- Idle check: all req_valid low for 10 cycles → req_ready=0, rsp_valid=0, busy=0 throughout.
